// File: rtl/ase_pcie_ss_pkg.sv
`default_nettype none
// ============================================================================
// Module : ase_pcie_ss_pkg
// Brief  : Shared PCIe SS emulation types, limits and completion-split helper.
// Rev    : 1.0  initial release
// ============================================================================
package ase_pcie_ss_pkg;

  typedef struct packed {
    int addr_w;
    int tag_w;
    int max_tags;
    int max_rd_req_bytes;
    int rcb_bytes;
    int cpl_chunk_bytes;
  } t_ase_pcie_ss_param_cfg;

  localparam t_ase_pcie_ss_param_cfg c_ase_pcie_ss_default_cfg = '{
    addr_w:           64,
    tag_w:            10,
    max_tags:         512,
    max_rd_req_bytes: 4096,
    rcb_bytes:        64,
    cpl_chunk_bytes:  256
  };

  localparam int PCIE_SS_MAX_BYTE_COUNT = 4096;
  localparam int c_pcie_ss_desc_tag_w   = 10;

  typedef struct packed {
    logic [c_pcie_ss_desc_tag_w-1:0] tag;
    logic [6:0]                      lower_addr;
    logic [11:0]                     byte_count;
    logic [9:0]                      length_dw;
    logic                            last;
  } t_ase_pcie_ss_cpl_desc;

  // Bytes carried by the next completion: stop at the next chunk-aligned
  // address or at the end of the request, whichever comes first.
  function automatic logic [12:0] ase_pcie_ss_cpl_chunk(
    input logic [12:0] addr_low,
    input logic [12:0] remaining,
    input logic [12:0] chunk_bytes
  );
    logic [12:0] offset;
    logic [12:0] to_boundary;
    offset      = addr_low & (chunk_bytes - 13'd1);
    to_boundary = chunk_bytes - offset;
    return (remaining < to_boundary) ? remaining : to_boundary;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ase_pcie_ss_rd_cpl_splitter.sv
`default_nettype none
// ============================================================================
// Module : ase_pcie_ss_rd_cpl_splitter
// Brief  : Splits one DMA read request into ordered CplD header descriptors.
// Rev    : 1.0  initial release
// ============================================================================
module ase_pcie_ss_rd_cpl_splitter
  import ase_pcie_ss_pkg::*;
#(
  parameter int ADDR_W           = c_ase_pcie_ss_default_cfg.addr_w,
  parameter int TAG_W            = c_ase_pcie_ss_default_cfg.tag_w,
  parameter int MAX_TAGS         = c_ase_pcie_ss_default_cfg.max_tags,
  parameter int MAX_RD_REQ_BYTES = c_ase_pcie_ss_default_cfg.max_rd_req_bytes,
  parameter int RCB_BYTES        = c_ase_pcie_ss_default_cfg.rcb_bytes,
  parameter int CPL_CHUNK_BYTES  = c_ase_pcie_ss_default_cfg.cpl_chunk_bytes
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [12:0]       req_len_bytes,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [TAG_W-1:0]  cpl_tag,
  output logic [6:0]        cpl_lower_addr,
  output logic [11:0]       cpl_byte_count,
  output logic [9:0]        cpl_length_dw,
  output logic              cpl_last,
  output logic              err_pulse
);

  generate
    if (!(RCB_BYTES > 0 && CPL_CHUNK_BYTES >= RCB_BYTES &&
          (CPL_CHUNK_BYTES & (CPL_CHUNK_BYTES - 1)) == 0 &&
          (CPL_CHUNK_BYTES % RCB_BYTES) == 0 &&
          CPL_CHUNK_BYTES <= MAX_RD_REQ_BYTES &&
          MAX_RD_REQ_BYTES <= PCIE_SS_MAX_BYTE_COUNT &&
          TAG_W <= c_pcie_ss_desc_tag_w && ADDR_W >= 13 &&
          MAX_TAGS <= (1 << TAG_W))) begin : g_bad_cfg
      $error("ase_pcie_ss_rd_cpl_splitter: illegal parameter combination");
    end
  endgenerate

  localparam logic [12:0] c_chunk_bytes = 13'(CPL_CHUNK_BYTES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } t_state;

  t_state                r_state;
  logic                  r_cpl_valid;
  logic                  r_err_pulse;
  t_ase_pcie_ss_cpl_desc r_desc;
  logic [ADDR_W-1:0]     r_cur_addr;
  logic [12:0]           r_remaining;
  logic [12:0]           r_chunk;

  logic                            w_req_fire;
  logic                            w_cpl_fire;
  logic                            w_req_legal;
  logic                            w_load;
  logic                            w_advance;
  logic [ADDR_W-1:0]               w_nxt_addr;
  logic [12:0]                     w_nxt_rem;
  logic [12:0]                     w_nxt_chunk;
  logic [c_pcie_ss_desc_tag_w-1:0] w_nxt_tag;

  // A new request may ride on the final handshake of the current one.
  assign req_ready  = rst_n && ((r_state == ST_IDLE) || (w_cpl_fire && r_desc.last));
  assign w_req_fire = req_valid && req_ready;
  assign w_cpl_fire = r_cpl_valid && cpl_ready;

  assign w_req_legal = (int'(req_tag) < MAX_TAGS) &&
                       (req_len_bytes != 13'd0) &&
                       (int'(req_len_bytes) <= MAX_RD_REQ_BYTES) &&
                       (req_addr[1:0] == 2'b00) &&
                       (req_len_bytes[1:0] == 2'b00);

  assign w_load    = w_req_fire && w_req_legal;
  assign w_advance = (r_state == ST_EMIT) && w_cpl_fire && !r_desc.last;

  assign w_nxt_addr  = w_load ? req_addr : r_cur_addr + ADDR_W'(r_chunk);
  assign w_nxt_rem   = w_load ? req_len_bytes : r_remaining - r_chunk;
  assign w_nxt_tag   = w_load ? c_pcie_ss_desc_tag_w'(req_tag) : r_desc.tag;
  assign w_nxt_chunk = ase_pcie_ss_cpl_chunk(w_nxt_addr[12:0], w_nxt_rem, c_chunk_bytes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cpl_valid <= 1'b0;
      r_err_pulse <= 1'b0;
      r_desc      <= '0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_chunk     <= '0;
    end else begin
      r_err_pulse <= w_req_fire && !w_req_legal;
      if (w_load || w_advance) begin
        r_state     <= ST_EMIT;
        r_cpl_valid <= 1'b1;
        r_cur_addr  <= w_nxt_addr;
        r_remaining <= w_nxt_rem;
        r_chunk     <= w_nxt_chunk;
        r_desc      <= '{tag:        w_nxt_tag,
                         lower_addr: w_nxt_addr[6:0],
                         byte_count: w_nxt_rem[11:0],
                         length_dw:  10'(w_nxt_chunk >> 2),
                         last:       (w_nxt_chunk == w_nxt_rem)};
      end else if (w_cpl_fire) begin
        r_state     <= ST_IDLE;
        r_cpl_valid <= 1'b0;
      end
    end
  end

  assign cpl_valid      = r_cpl_valid;
  assign cpl_tag        = r_desc.tag[TAG_W-1:0];
  assign cpl_lower_addr = r_desc.lower_addr;
  assign cpl_byte_count = r_desc.byte_count;
  assign cpl_length_dw  = r_desc.length_dw;
  assign cpl_last       = r_desc.last;
  assign err_pulse      = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ase_pcie_ss_rd_cpl_splitter.sv
`default_nettype none
// ============================================================================
// Module : tb_ase_pcie_ss_rd_cpl_splitter
// Brief  : Directed + randomized bench with a request-level completion model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ase_pcie_ss_rd_cpl_splitter;

  localparam int CHUNK = 256;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_tag;
  logic [63:0] req_addr;
  logic [12:0] req_len_bytes;
  logic        cpl_valid;
  logic        cpl_ready;
  logic [9:0]  cpl_tag;
  logic [6:0]  cpl_lower_addr;
  logic [11:0] cpl_byte_count;
  logic [9:0]  cpl_length_dw;
  logic        cpl_last;
  logic        err_pulse;

  ase_pcie_ss_rd_cpl_splitter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_tag        (req_tag),
    .req_addr       (req_addr),
    .req_len_bytes  (req_len_bytes),
    .cpl_valid      (cpl_valid),
    .cpl_ready      (cpl_ready),
    .cpl_tag        (cpl_tag),
    .cpl_lower_addr (cpl_lower_addr),
    .cpl_byte_count (cpl_byte_count),
    .cpl_length_dw  (cpl_length_dw),
    .cpl_last       (cpl_last),
    .err_pulse      (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cpl    = 0;
  int ready_mode = 1;  // 0 hold low, 1 always high, 2 toggle, 3 random
  logic [39:0] exp_q[$];
  logic        err_due = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit is_legal(input logic [9:0] t, input logic [63:0] a, input logic [12:0] l);
    return (t < 10'd512) && (l != 0) && (l <= 13'd4096) && (a % 4 == 0) && (l % 4 == 0);
  endfunction

  // Request-level model: walk the byte range, cutting at every 256-byte line.
  task automatic model_push(input logic [9:0] t, input logic [63:0] a0, input int len);
    logic [63:0] a;
    int rem, to_b, ch;
    logic [11:0] bc;
    logic [9:0]  ldw;
    a = a0;
    rem = len;
    while (rem > 0) begin
      to_b = CHUNK - int'(a % 64'd256);
      ch   = (rem < to_b) ? rem : to_b;
      bc   = 12'(rem);
      ldw  = 10'(ch / 4);
      exp_q.push_back({t, a[6:0], bc, ldw, (ch == rem) ? 1'b1 : 1'b0});
      a   = a + 64'(ch);
      rem = rem - ch;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      err_due = 1'b0;
      check("rst_cpl_valid", cpl_valid, 0);
      check("rst_req_ready", req_ready, 0);
    end else begin
      check("req_ready", req_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && cpl_ready));
      check("err_pulse", err_pulse, err_due);
      err_due = 1'b0;
      check("cpl_valid", cpl_valid, exp_q.size() != 0);
      if (cpl_valid && exp_q.size() != 0) begin
        check("cpl_desc", {cpl_tag, cpl_lower_addr, cpl_byte_count, cpl_length_dw, cpl_last}, exp_q[0]);
        if (cpl_ready) begin
          void'(exp_q.pop_front());
          n_cpl++;
        end
      end
      if (req_valid && req_ready) begin
        if (is_legal(req_tag, req_addr, req_len_bytes)) model_push(req_tag, req_addr, int'(req_len_bytes));
        else err_due = 1'b1;
      end
    end
  end

  initial begin
    cpl_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       cpl_ready = 1'b0;
        1:       cpl_ready = 1'b1;
        2:       cpl_ready = ~cpl_ready;
        default: cpl_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_req(input logic [9:0] t, input logic [63:0] a, input logic [12:0] l);
    int k;
    req_valid = 1'b1;
    req_tag = t;
    req_addr = a;
    req_len_bytes = l;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready && k < 4000);
    if (!req_ready) check("req_accept_timeout", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      @(posedge clk);
      k++;
    end
    check("drain_timeout", exp_q.size() == 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [9:0]  t;
    logic [63:0] a;
    logic [12:0] l;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_tag = '0;
    req_addr = '0;
    req_len_bytes = '0;
    #2;
    check("reset_outputs", {cpl_valid, req_ready, err_pulse, cpl_byte_count, cpl_length_dw, cpl_last}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single descriptor, one-cycle latency
    ready_mode = 1;
    base = n_cpl;
    send_req(10'd5, 64'h1000, 13'd64);
    check("s1_latency_valid", cpl_valid, 1);
    check("s1_desc", {cpl_tag, cpl_lower_addr, cpl_byte_count, cpl_length_dw, cpl_last}, {10'd5, 7'h00, 12'd64, 10'd16, 1'b1});
    drain();
    check("s1_count", n_cpl - base, 1);

    // three descriptors across 256-byte lines
    base = n_cpl;
    send_req(10'd6, 64'h10C0, 13'd512);
    check("s2_first", {cpl_lower_addr, cpl_byte_count, cpl_length_dw, cpl_last}, {7'h40, 12'd512, 10'd16, 1'b0});
    drain();
    check("s2_count", n_cpl - base, 3);

    // maximum length: byte_count 4096 encodes as zero
    base = n_cpl;
    send_req(10'd7, 64'h2000, 13'd4096);
    check("s3_first", {cpl_byte_count, cpl_length_dw, cpl_last}, {12'd0, 10'd64, 1'b0});
    drain();
    check("s3_count", n_cpl - base, 16);

    // toggling ready with a back-to-back second request
    ready_mode = 2;
    base = n_cpl;
    send_req(10'd8, 64'h10C0, 13'd512);
    send_req(10'd9, 64'h1000, 13'd64);
    drain();
    check("s4_count", n_cpl - base, 4);

    // illegal requests: accepted, err pulse, no descriptors
    ready_mode = 1;
    base = n_cpl;
    send_req(10'd600, 64'h1000, 13'd64);
    check("s5_err_tag", err_pulse, 1);
    send_req(10'd1, 64'h1000, 13'd6);
    check("s5_err_len", err_pulse, 1);
    send_req(10'd1, 64'h1002, 13'd64);
    check("s5_err_addr", err_pulse, 1);
    check("s5_ready_after", req_ready, 1);
    send_req(10'd1, 64'h1000, 13'd4100);
    check("s5_err_big", err_pulse, 1);
    drain();
    check("s5_count", n_cpl - base, 0);

    // reset in the middle of a request
    ready_mode = 0;
    send_req(10'd11, 64'h0, 13'd512);
    check("s6_first_valid", cpl_valid, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("s6_rst_outputs", {cpl_valid, req_ready, err_pulse, cpl_byte_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    base = n_cpl;
    send_req(10'd12, 64'h3000, 13'd64);
    check("s6_desc", {cpl_tag, cpl_lower_addr, cpl_byte_count, cpl_length_dw, cpl_last}, {10'd12, 7'h00, 12'd64, 10'd16, 1'b1});
    drain();
    check("s6_count", n_cpl - base, 1);

    // randomized traffic, including address wrap and illegal requests
    ready_mode = 3;
    for (int i = 0; i < 80; i++) begin
      t = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(512, 1023)) : 10'($urandom_range(0, 511));
      a = {$urandom(), $urandom()};
      if ($urandom_range(0, 5) == 0) a = 64'hFFFF_FFFF_FFFF_FE00 | 64'($urandom_range(0, 511));
      if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
      l = 13'($urandom_range(1, 1024) * 4);
      case ($urandom_range(0, 11))
        0:       l = 13'($urandom_range(1, 4095));
        1:       l = 13'd0;
        2:       l = 13'd4096;
        default: ;
      endcase
      send_req(t, a, l);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ready_mode = 1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
